conv1d_mac_seq: RTL and testbench
=================================

# conv1d_mac_seq

Parametrised, multi-cycle successor to the single-cycle conv1d CFU datapath. It holds a circular window of KERNEL_LENGTH input slots and matching weights in local buffers, and computes one output point as a bias-seeded dot product. A LANES-wide MAC array processes the input channels over several cycles. It sits behind the CFU command port with full valid/ready handshaking on both command and response, so the CPU stalls correctly during long computes.

## Interface
- KERNEL_LENGTH, 8, taps per filter (power of two)
- MAX_CHANNELS, 128, maximum input depth
- LANES, 4, MACs per cycle (divides MAX_CHANNELS)
- DATA_W, 8, signed input/weight width
- ACC_W, 32, accumulator and bias width
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both high
- cmd  in  7  opcode
- inp0  in  32  address / unused
- inp1  in  32  value
- rsp_valid  out  1  response beat valid
- rsp_ready  in  1  response consumed when both high
- ret  out  32  response data
- busy  out  1  high while in COMPUTE

## Operation
- Opcodes:
  - 10: write input[inp0] = inp1[DATA_W-1:0]
  - 11: write weight[inp0]
  - 13: read input
  - 14: read weight
  - 20: input_offset = inp1 (signed 32)
  - 26: input_depth = inp1
  - 30: bias = inp1
  - 44: start_x = inp1 mod KERNEL_LENGTH
  - 41: start compute
  - 43: read acc
  - Others: no-op.
- Buffer addressing: buffer index = slot*input_depth + ch, buffer size KERNEL_LENGTH*MAX_CHANNELS. Out-of-range writes are ignored; out-of-range reads return 0.
- Every accepted command produces exactly one response beat.
  - Reads return the value sign-extended to 32 bits.
  - Write, parameter and no-op commands return 0.
  - 41 returns the final acc.
- Compute definition: acc = bias + Σ over f = 0..K-1 and c = 0..depth-1 of w[f*depth+c] * (x[((f+start_x) mod K)*depth+c] + input_offset).
  - The sum of the input and the offset is formed at 33 bits signed.
  - Products and the sum wrap modulo 2^ACC_W.
- Each compute cycle processes LANES channels of one tap. Lanes with c ≥ depth contribute 0.
- Valid input_depth range is 1..MAX_CHANNELS. Writes outside that range clamp to the range.
- FSM states:
  - IDLE: on accept of 41, go to COMPUTE. On any other accepted command, execute it and load the response register.
  - COMPUTE: advance the channel group, then the tap. After the last group of the last tap, go to RESP.
  - RESP: rsp_valid = 1. On rsp_ready, go to IDLE.
- Responses from non-compute commands use the same single-entry response register, which is shared with RESP.

## Timing
- cmd_ready = (state==IDLE) && (!rsp_valid || rsp_ready). No command is accepted during COMPUTE.
- Non-compute commands: response valid on the cycle after accept (1-cycle latency). Back-to-back accepts are allowed when rsp_ready is held high.
- Compute latency: KERNEL_LENGTH*ceil(input_depth/LANES) COMPUTE cycles, then rsp_valid in the next cycle. Example: depth 3, LANES 4 gives 8 cycles.
- rsp_valid and ret hold stable until rsp_ready.
- Parameter writes take effect for any compute accepted on a later cycle.
- Reset values:
  - Outputs: rsp_valid 0, ret 0, busy 0, cmd_ready 1 (after reset release).
  - Registers: acc 0, bias 0, input_offset 0, start_x 0, input_depth 1.
  - Buffers are not reset.
- Reset asserted mid-compute aborts the compute with no response. The FSM returns to IDLE.

## Structure
- Package conv1d_pkg holds:
  - The opcode localparams.
  - The state enum {IDLE, COMPUTE, RESP}.
  - A function computing the tap index (f+start_x) mod K as a mask.
- Sub-module conv1d_mac_lanes: combinational LANES-wide signed dot product with a lane-valid mask. It returns an ACC_W partial sum.
- The top level holds the FSM, counters, buffers and the response register.

## Test plan
- Reset, then read 43 and 13 at address 0 with the buffers preloaded to 0 -> ret 0. After reset release, cmd_ready is 1 and rsp_valid is 0.
- Setup:
  - depth 3, all weights 1, inputs x[slot*3+c] = slot, offset 0, bias 10, start_x 0.
  - Issue 41 -> busy for 8 cycles, then ret = 10 + 3*28 = 94.
- Same data with offset 128 and start_x 5 -> ret = 10 + 3*(28+8*128) = 3166. The result is rotation-invariant, which checks the mod wrap.
- Hold rsp_ready low for 5 cycles after a 13 read -> ret stable, cmd_ready 0. Then release -> next command accepted the same cycle.
- depth 128, weights 127, inputs 127, offset 127 -> wrap-free sum 1024*127*254 = 33032192.
- Assert reset_n low mid-COMPUTE -> no rsp_valid, busy 0. A subsequent 41 completes normally.

Source files
------------

// File: rtl/conv1d_pkg.sv
// Shared opcodes, FSM state type and tap-rotation helper for the sequential
// 1-D convolution MAC unit.
package conv1d_pkg;

  localparam logic [6:0] OP_WR_INPUT  = 7'd10;
  localparam logic [6:0] OP_WR_WEIGHT = 7'd11;
  localparam logic [6:0] OP_RD_INPUT  = 7'd13;
  localparam logic [6:0] OP_RD_WEIGHT = 7'd14;
  localparam logic [6:0] OP_SET_OFFS  = 7'd20;
  localparam logic [6:0] OP_SET_DEPTH = 7'd26;
  localparam logic [6:0] OP_SET_BIAS  = 7'd30;
  localparam logic [6:0] OP_START     = 7'd41;
  localparam logic [6:0] OP_RD_ACC    = 7'd43;
  localparam logic [6:0] OP_SET_START = 7'd44;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    RESP    = 2'd2
  } state_t;

  // Kernel length is a power of two, so the circular wrap is a mask.
  function automatic logic [31:0] tap_index(input logic [31:0] f,
                                            input logic [31:0] start,
                                            input logic [31:0] k_mask);
    tap_index = (f + start) & k_mask;
  endfunction

endpackage

// File: rtl/conv1d_mac_seq_if.sv
// CFU command/response port: valid/ready on both directions plus busy status.
interface conv1d_mac_seq_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [6:0]  cmd;
  logic [31:0] inp0;
  logic [31:0] inp1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] ret;
  logic        busy;

  modport master (
    output cmd_valid, cmd, inp0, inp1, rsp_ready,
    input  cmd_ready, rsp_valid, ret, busy
  );

  modport slave (
    input  cmd_valid, cmd, inp0, inp1, rsp_ready,
    output cmd_ready, rsp_valid, ret, busy
  );
endinterface

// File: rtl/conv1d_mac_lanes.sv
// Combinational LANES-wide dot product of weights with offset-adjusted inputs;
// disabled lanes contribute nothing and all arithmetic wraps at ACC_W bits.
module conv1d_mac_lanes #(
  parameter int LANES  = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic [LANES-1:0][DATA_W-1:0] x_vec,
  input  logic [LANES-1:0][DATA_W-1:0] w_vec,
  input  logic [LANES-1:0]             lane_en,
  input  logic [31:0]                  offset,
  output logic [ACC_W-1:0]             partial
);

  // Offset sum needs 33 bits; the extra product width is truncated away.
  localparam int PW = 33 + DATA_W;

  logic [PW-1:0] sum_s  [LANES];
  logic [PW-1:0] wext_s [LANES];
  logic [PW-1:0] prod_s [LANES];

  // Per-lane multiply and reduction into one partial sum.
  always_comb begin
    partial = {ACC_W{1'b0}};
    for (int l = 0; l < LANES; l++) begin
      sum_s[l]  = {{(PW-DATA_W){x_vec[l][DATA_W-1]}}, x_vec[l]}
                + {{(PW-32){offset[31]}}, offset};
      wext_s[l] = {{(PW-DATA_W){w_vec[l][DATA_W-1]}}, w_vec[l]};
      prod_s[l] = sum_s[l] * wext_s[l];
      if (lane_en[l]) begin
        partial = partial + prod_s[l][ACC_W-1:0];
      end else begin
        partial = partial;
      end
    end
  end

endmodule

// File: rtl/conv1d_mac_seq.sv
// Multi-cycle conv1d CFU: buffered window and weights, bias-seeded dot product
// computed LANES channels per cycle behind a valid/ready command port.
module conv1d_mac_seq
  import conv1d_pkg::*;
#(
  parameter int KERNEL_LENGTH = 8,
  parameter int MAX_CHANNELS  = 128,
  parameter int LANES         = 4,
  parameter int DATA_W        = 8,
  parameter int ACC_W         = 32
) (
  input logic              clk,
  input logic              reset_n,
  conv1d_mac_seq_if.slave  bus
);

  localparam int          BUF_N  = KERNEL_LENGTH * MAX_CHANNELS;
  localparam int          AW     = $clog2(BUF_N);
  localparam int          EXT_W  = 32 - DATA_W;
  localparam logic [31:0] BUF_W  = BUF_N;
  localparam logic [31:0] K_MASK = KERNEL_LENGTH - 1;
  localparam logic [31:0] LANE_W = LANES;
  localparam logic [31:0] MAXC_W = MAX_CHANNELS;

  logic [DATA_W-1:0] x_buf [BUF_N];
  logic [DATA_W-1:0] w_buf [BUF_N];

  state_t            state_r;
  logic [ACC_W-1:0]  acc_r;
  logic [ACC_W-1:0]  bias_r;
  logic [31:0]       offset_r;
  logic [31:0]       start_r;
  logic [31:0]       depth_r;
  logic [31:0]       tap_r;
  logic [31:0]       ch_r;
  logic              rsp_valid_r;
  logic [31:0]       ret_r;
  logic              busy_r;

  logic              accept_s;
  logic              addr_ok_s;
  logic [AW-1:0]     addr_s;
  logic [31:0]       rd_data_s;
  logic [31:0]       depth_in_s;
  logic [31:0]       x_tap_s;
  logic              last_grp_s;
  logic              last_tap_s;
  logic [ACC_W-1:0]  partial_s;
  logic [31:0]       ch_s    [LANES];
  logic [31:0]       x_idx_s [LANES];
  logic [31:0]       w_idx_s [LANES];
  logic [LANES-1:0][DATA_W-1:0] x_vec_s;
  logic [LANES-1:0][DATA_W-1:0] w_vec_s;
  logic [LANES-1:0]             lane_en_s;

  assign bus.cmd_ready = (state_r == IDLE) && (!rsp_valid_r || bus.rsp_ready);
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.ret       = ret_r;
  assign bus.busy      = busy_r;

  assign accept_s   = bus.cmd_valid && bus.cmd_ready;
  assign addr_ok_s  = bus.inp0 < BUF_W;
  assign addr_s     = bus.inp0[AW-1:0];
  assign x_tap_s    = tap_index(tap_r, start_r, K_MASK);
  assign last_grp_s = (ch_r + LANE_W) >= depth_r;
  assign last_tap_s = tap_r == K_MASK;

  // Response data for non-compute commands; reads sign-extend, others give 0.
  always_comb begin
    rd_data_s = 32'd0;
    case (bus.cmd)
      OP_RD_INPUT: begin
        if (addr_ok_s) rd_data_s = {{EXT_W{x_buf[addr_s][DATA_W-1]}}, x_buf[addr_s]};
        else           rd_data_s = 32'd0;
      end
      OP_RD_WEIGHT: begin
        if (addr_ok_s) rd_data_s = {{EXT_W{w_buf[addr_s][DATA_W-1]}}, w_buf[addr_s]};
        else           rd_data_s = 32'd0;
      end
      OP_RD_ACC: rd_data_s = acc_r[31:0];
      default:   rd_data_s = 32'd0;
    endcase
  end

  // Clamp requested depth into 1..MAX_CHANNELS.
  always_comb begin
    if (bus.inp1 == 32'd0)        depth_in_s = 32'd1;
    else if (bus.inp1 > MAXC_W)   depth_in_s = MAXC_W;
    else                          depth_in_s = bus.inp1;
  end

  // Gather one channel group of the current tap; lanes past depth are masked.
  always_comb begin
    x_vec_s   = {(LANES*DATA_W){1'b0}};
    w_vec_s   = {(LANES*DATA_W){1'b0}};
    lane_en_s = {LANES{1'b0}};
    for (int l = 0; l < LANES; l++) begin
      ch_s[l]    = ch_r + 32'(l);
      x_idx_s[l] = x_tap_s * depth_r + ch_s[l];
      w_idx_s[l] = tap_r * depth_r + ch_s[l];
      if (ch_s[l] < depth_r) begin
        lane_en_s[l] = 1'b1;
        x_vec_s[l]   = x_buf[x_idx_s[l][AW-1:0]];
        w_vec_s[l]   = w_buf[w_idx_s[l][AW-1:0]];
      end else begin
        lane_en_s[l] = 1'b0;
        x_vec_s[l]   = {DATA_W{1'b0}};
        w_vec_s[l]   = {DATA_W{1'b0}};
      end
    end
  end

  conv1d_mac_lanes #(
    .LANES  (LANES),
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_lanes (
    .x_vec   (x_vec_s),
    .w_vec   (w_vec_s),
    .lane_en (lane_en_s),
    .offset  (offset_r),
    .partial (partial_s)
  );

  // Buffer writes; contents survive reset.
  always_ff @(posedge clk) begin
    if (accept_s && addr_ok_s) begin
      case (bus.cmd)
        OP_WR_INPUT:  x_buf[addr_s] <= bus.inp1[DATA_W-1:0];
        OP_WR_WEIGHT: w_buf[addr_s] <= bus.inp1[DATA_W-1:0];
        default: ;
      endcase
    end
  end

  // Control FSM, parameter registers and the single-entry response register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      acc_r       <= {ACC_W{1'b0}};
      bias_r      <= {ACC_W{1'b0}};
      offset_r    <= 32'd0;
      start_r     <= 32'd0;
      depth_r     <= 32'd1;
      tap_r       <= 32'd0;
      ch_r        <= 32'd0;
      rsp_valid_r <= 1'b0;
      ret_r       <= 32'd0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s && bus.cmd == OP_START) begin
            state_r     <= COMPUTE;
            busy_r      <= 1'b1;
            acc_r       <= bias_r;
            tap_r       <= 32'd0;
            ch_r        <= 32'd0;
            rsp_valid_r <= 1'b0;
          end else if (accept_s) begin
            rsp_valid_r <= 1'b1;
            ret_r       <= rd_data_s;
            case (bus.cmd)
              OP_SET_OFFS:  offset_r <= bus.inp1;
              OP_SET_DEPTH: depth_r  <= depth_in_s;
              OP_SET_BIAS:  bias_r   <= bus.inp1[ACC_W-1:0];
              OP_SET_START: start_r  <= bus.inp1 & K_MASK;
              default: ;
            endcase
          end else if (rsp_valid_r && bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
          end
        end
        COMPUTE: begin
          acc_r <= acc_r + partial_s;
          if (last_grp_s) begin
            ch_r <= 32'd0;
            if (last_tap_s) begin
              state_r     <= RESP;
              busy_r      <= 1'b0;
              rsp_valid_r <= 1'b1;
              ret_r       <= acc_r[31:0] + partial_s[31:0];
            end else begin
              tap_r <= tap_r + 32'd1;
            end
          end else begin
            ch_r <= ch_r + LANE_W;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv1d_mac_seq.sv
// Scenario-based bench for conv1d_mac_seq; expected responses go through a
// scoreboard queue when commands are issued and are checked as they return.
module tb_conv1d_mac_seq;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  conv1d_mac_seq_if bus ();

  conv1d_mac_seq #(
    .KERNEL_LENGTH (8),
    .MAX_CHANNELS  (128),
    .LANES         (4),
    .DATA_W        (8),
    .ACC_W         (32)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];

  // Offer one command and return on the falling edge after it is accepted.
  task automatic drive(input logic [6:0] op, input logic [31:0] a, input logic [31:0] v);
    bit ok;
    ok = 1'b0;
    bus.cmd = op; bus.inp0 = a; bus.inp1 = v; bus.cmd_valid = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      #1;
      if (bus.cmd_ready === 1'b1) ok = 1'b1;
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout op=%0d cmd_ready=%b required=1", op, bus.cmd_ready);
    end
  endtask

  // Wait (bounded) for rsp_valid, counting cycles with busy high on the way.
  task automatic wait_rsp(input int budget, output int busy_cycles);
    busy_cycles = 0;
    for (int i = 0; i < budget && bus.rsp_valid !== 1'b1; i++) begin
      if (bus.busy === 1'b1) busy_cycles++;
      @(negedge clk);
    end
    if (bus.rsp_valid !== 1'b1) begin
      checks++; errors++;
      $display("FAIL rsp_timeout rsp_valid=%b required=1", bus.rsp_valid);
    end
  endtask

  task automatic test_reset();
    int bc;
    logic [31:0] e;
    logic [6:0] ops [3];
    ops[0] = 7'd10; ops[1] = 7'd13; ops[2] = 7'd43;
    bus.cmd_valid = 1'b0; bus.rsp_ready = 1'b1;
    bus.cmd = 7'd0; bus.inp0 = 32'd0; bus.inp1 = 32'd0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got=%b exp=0", bus.rsp_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.ret !== 32'd0) begin errors++; $display("FAIL rst_ret got=%0d exp=0", bus.ret); end
    reset_n = 1'b1;
    #1;
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready got=%b exp=1", bus.cmd_ready); end
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(32'd0);
      drive(ops[i], 32'd0, 32'd0);
      wait_rsp(4, bc);
      e = exp_q.pop_front();
      checks++; if (bus.ret !== e) begin errors++; $display("FAIL rst_read op=%0d got=%0d exp=%0d", ops[i], bus.ret, e); end
    end
  endtask

  task automatic test_compute_basic();
    int bc;
    logic [6:0]  op;
    logic [31:0] a, v, e;
    // Params, 24 weights of 1, inputs x[slot*3+c] = slot, then edge accesses.
    for (int i = 0; i < 52; i++) begin
      case (i)
        0: begin op = 7'd26; a = 32'd0; v = 32'd3;  end
        1: begin op = 7'd20; a = 32'd0; v = 32'd0;  end
        2: begin op = 7'd30; a = 32'd0; v = 32'd10; end
        3: begin op = 7'd44; a = 32'd0; v = 32'd0;  end
        default: begin
          if (i < 28) begin op = 7'd11; a = 32'(i - 4);  v = 32'd1; end
          else        begin op = 7'd10; a = 32'(i - 28); v = 32'((i - 28) / 3); end
        end
      endcase
      exp_q.push_back(32'd0);
      drive(op, a, v);
      wait_rsp(4, bc);
      e = exp_q.pop_front();
      checks++; if (bus.ret !== e) begin errors++; $display("FAIL setup_wr i=%0d got=%0d exp=%0d", i, bus.ret, e); end
    end
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin op = 7'd10; a = 32'd1024; v = 32'd5;    e = 32'd0; end
        1: begin op = 7'd13; a = 32'd1024; v = 32'd0;    e = 32'd0; end
        2: begin op = 7'd10; a = 32'd100;  v = 32'h180;  e = 32'd0; end
        3: begin op = 7'd13; a = 32'd100;  v = 32'd0;    e = 32'hFFFF_FF80; end
        default: begin op = 7'd14; a = 32'd5; v = 32'd0; e = 32'd1; end
      endcase
      exp_q.push_back(e);
      drive(op, a, v);
      wait_rsp(4, bc);
      e = exp_q.pop_front();
      checks++; if (bus.ret !== e) begin errors++; $display("FAIL edge_access i=%0d got=%0h exp=%0h", i, bus.ret, e); end
    end
    exp_q.push_back(32'd94);
    drive(7'd41, 32'd0, 32'd0);
    checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL busy_cmd_ready got=%b exp=0", bus.cmd_ready); end
    wait_rsp(100, bc);
    checks++; if (bc != 8) begin errors++; $display("FAIL basic_latency got=%0d exp=8", bc); end
    e = exp_q.pop_front();
    checks++; if (bus.ret !== e) begin errors++; $display("FAIL basic_acc got=%0d exp=%0d", bus.ret, e); end
    exp_q.push_back(32'd94);
    drive(7'd43, 32'd0, 32'd0);
    wait_rsp(4, bc);
    e = exp_q.pop_front();
    checks++; if (bus.ret !== e) begin errors++; $display("FAIL read_acc got=%0d exp=%0d", bus.ret, e); end
  endtask

  task automatic test_rotation();
    int bc;
    logic [31:0] e;
    logic [6:0]  ops  [5];
    logic [31:0] vals [5];
    logic [31:0] exps [5];
    // offset 128, start 13 -> 5, compute, clamp depth 0 -> 1, compute.
    ops[0] = 7'd20; vals[0] = 32'd128; exps[0] = 32'd0;
    ops[1] = 7'd44; vals[1] = 32'd13;  exps[1] = 32'd0;
    ops[2] = 7'd41; vals[2] = 32'd0;   exps[2] = 32'd3166;
    ops[3] = 7'd26; vals[3] = 32'd0;   exps[3] = 32'd0;
    ops[4] = 7'd41; vals[4] = 32'd0;   exps[4] = 32'd1041;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(exps[i]);
      drive(ops[i], 32'd0, vals[i]);
      wait_rsp(100, bc);
      e = exp_q.pop_front();
      checks++; if (bus.ret !== e) begin errors++; $display("FAIL rotation i=%0d got=%0d exp=%0d", i, bus.ret, e); end
      if (ops[i] == 7'd41) begin
        checks++; if (bc != 8) begin errors++; $display("FAIL rotation_latency i=%0d got=%0d exp=8", i, bc); end
      end
    end
  endtask

  task automatic test_backpressure();
    int bc;
    logic [31:0] e;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    exp_q.push_back(32'hFFFF_FF80);
    drive(7'd13, 32'd100, 32'd0);
    bus.cmd = 7'd14; bus.inp0 = 32'd5; bus.inp1 = 32'd0; bus.cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.ret !== exp_q[0] || bus.cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold cyc=%0d valid=%b ret=%0h ready=%b exp valid=1 ret=%0h ready=0",
                 i, bus.rsp_valid, bus.ret, bus.cmd_ready, exp_q[0]);
      end
      @(negedge clk);
    end
    e = exp_q.pop_front();
    checks++; if (bus.ret !== e) begin errors++; $display("FAIL hold_ret got=%0h exp=%0h", bus.ret, e); end
    exp_q.push_back(32'd1);
    bus.rsp_ready = 1'b1;
    #1;
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL release_ready got=%b exp=1", bus.cmd_ready); end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    wait_rsp(2, bc);
    e = exp_q.pop_front();
    checks++; if (bus.ret !== e) begin errors++; $display("FAIL release_rsp got=%0h exp=%0h", bus.ret, e); end
  endtask

  task automatic test_full_depth();
    int bc;
    logic [6:0]  op;
    logic [31:0] a, v, e;
    // depth 200 clamps to 128; 1024 weights and inputs of 127, offset 127.
    for (int i = 0; i < 2052; i++) begin
      case (i)
        0: begin op = 7'd26; a = 32'd0; v = 32'd200; end
        1: begin op = 7'd20; a = 32'd0; v = 32'd127; end
        2: begin op = 7'd30; a = 32'd0; v = 32'd0;   end
        3: begin op = 7'd44; a = 32'd0; v = 32'd0;   end
        default: begin
          if (i < 1028) begin op = 7'd11; a = 32'(i - 4);    v = 32'd127; end
          else          begin op = 7'd10; a = 32'(i - 1028); v = 32'd127; end
        end
      endcase
      exp_q.push_back(32'd0);
      drive(op, a, v);
      wait_rsp(4, bc);
      e = exp_q.pop_front();
      checks++; if (bus.ret !== e) begin errors++; $display("FAIL full_wr i=%0d got=%0d exp=%0d", i, bus.ret, e); end
    end
    exp_q.push_back(32'd33032192);
    drive(7'd41, 32'd0, 32'd0);
    wait_rsp(400, bc);
    checks++; if (bc != 256) begin errors++; $display("FAIL full_latency got=%0d exp=256", bc); end
    e = exp_q.pop_front();
    checks++; if (bus.ret !== e) begin errors++; $display("FAIL full_acc got=%0d exp=%0d", bus.ret, e); end
  endtask

  task automatic test_reset_abort();
    int bc;
    logic [31:0] e;
    @(negedge clk);
    drive(7'd41, 32'd0, 32'd0);
    repeat (10) @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL abort_midbusy got=%b exp=1", bus.busy); end
    reset_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL abort_state busy=%b rsp_valid=%b exp 0 0", bus.busy, bus.rsp_valid);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL abort_no_rsp got=%b exp=0", bus.rsp_valid); end
    // Registers are back to defaults (depth 1, offset 0, bias 0); buffers keep 127s.
    exp_q.push_back(32'd129032);
    drive(7'd41, 32'd0, 32'd0);
    wait_rsp(100, bc);
    checks++; if (bc != 8) begin errors++; $display("FAIL after_abort_latency got=%0d exp=8", bc); end
    e = exp_q.pop_front();
    checks++; if (bus.ret !== e) begin errors++; $display("FAIL after_abort_acc got=%0d exp=%0d", bus.ret, e); end
  endtask

  initial begin
    test_reset();
    test_compute_basic();
    test_rotation();
    test_backpressure();
    test_full_depth();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
